// File: rtl/store_unit_mq_if.sv
// Store request channel: valid/ready handshake carrying one store
// (virtual address, unshifted data, unshifted byte mask, size, transaction id).
// master drives the request fields and valid; slave returns ready.
interface store_unit_mq_if #(
    parameter int unsigned XLEN          = 64,
    parameter int unsigned VLEN          = 39,
    parameter int unsigned TRANS_ID_BITS = 3
);
    logic                     valid;
    logic                     ready;
    logic [VLEN-1:0]          vaddr;
    logic [XLEN-1:0]          data;
    logic [XLEN/8-1:0]        be;
    logic [1:0]               size;
    logic [TRANS_ID_BITS-1:0] trans_id;

    modport master (
        output valid, vaddr, data, be, size, trans_id,
        input  ready
    );

    modport slave (
        input  valid, vaddr, data, be, size, trans_id,
        output ready
    );
endinterface

// File: rtl/store_unit_mq.sv
// Store unit: queues stores, translates the head address through the MMU and
// hands the aligned store to the store buffer, then writes back the id.
// Latency: store out in the same cycle as a dTLB hit with buffer ready;
// writeback one cycle after the pop.
// Backpressure: ready drops when the queue is full; a stalled store buffer
// parks the translated head in WAIT_BUF with st_* held stable.
// Ports: clk_i/rst_ni/flush_i, req_if (store request channel), MMU
// (translation_req_o, vaddr_o, dtlb_hit_i, paddr_i, ex_valid_i), store buffer
// (st_*), writeback (wb_*), occupancy (count_o, empty_o).
module store_unit_mq #(
    parameter int unsigned XLEN          = 64,
    parameter int unsigned VLEN          = 39,
    parameter int unsigned PLEN          = 56,
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned TRANS_ID_BITS = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    store_unit_mq_if.slave             req_if,
    output logic                       translation_req_o,
    output logic [VLEN-1:0]            vaddr_o,
    input  logic                       dtlb_hit_i,
    input  logic [PLEN-1:0]            paddr_i,
    input  logic                       ex_valid_i,
    output logic                       st_valid_o,
    input  logic                       st_ready_i,
    output logic [PLEN-1:0]            st_paddr_o,
    output logic [XLEN-1:0]            st_data_o,
    output logic [XLEN/8-1:0]          st_be_o,
    output logic [1:0]                 st_size_o,
    output logic                       wb_valid_o,
    output logic [TRANS_ID_BITS-1:0]   wb_trans_id_o,
    output logic                       wb_ex_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o
);
    localparam int unsigned BW = XLEN / 8;
    localparam int unsigned OB = $clog2(BW);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [VLEN-1:0]          vaddr;
        logic [XLEN-1:0]          data;
        logic [BW-1:0]            be;
        logic [1:0]               size;
        logic [TRANS_ID_BITS-1:0] trans_id;
    } entry_t;

    typedef enum logic [1:0] {IDLE, XLATE, WAIT_BUF} state_e;

    entry_t                   mem_q [DEPTH];
    entry_t                   head;
    logic [PW-1:0]            wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]            count_q, count_d;
    state_e                   state_q, state_d;
    logic [PLEN-1:0]          paddr_q, paddr_d;
    logic                     wb_valid_q, wb_ex_q;
    logic [TRANS_ID_BITS-1:0] wb_trans_id_q;
    logic                     push, pop, pop_ex;
    logic [OB-1:0]            byte_off;

    // Explicit wrap keeps non-power-of-two pointer widths (DEPTH=1) correct.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head         = mem_q[rd_ptr_q];
    assign req_if.ready = (count_q < CW'(DEPTH));
    assign push         = req_if.valid & req_if.ready & ~flush_i;

    assign vaddr_o   = head.vaddr;
    assign byte_off  = head.vaddr[OB-1:0];
    assign st_data_o = head.data << {byte_off, 3'b000};
    assign st_be_o   = head.be << byte_off;
    assign st_size_o = head.size;

    assign wb_valid_o    = wb_valid_q;
    assign wb_trans_id_o = wb_trans_id_q;
    assign wb_ex_o       = wb_ex_q;
    assign count_o       = count_q;
    assign empty_o       = (count_q == '0);

    always_comb begin
        state_d           = state_q;
        paddr_d           = paddr_q;
        translation_req_o = 1'b0;
        st_valid_o        = 1'b0;
        st_paddr_o        = paddr_q;
        pop               = 1'b0;
        pop_ex            = 1'b0;

        case (state_q)
            XLATE: begin
                translation_req_o = 1'b1;
                st_paddr_o        = paddr_i;
                if (dtlb_hit_i) begin
                    if (ex_valid_i) begin
                        pop    = 1'b1;
                        pop_ex = 1'b1;
                    end else if (st_ready_i) begin
                        st_valid_o = 1'b1;
                        pop        = 1'b1;
                    end else begin
                        paddr_d = paddr_i;
                        state_d = WAIT_BUF;
                    end
                end
            end
            WAIT_BUF: begin
                st_valid_o = 1'b1;
                pop        = st_ready_i;
            end
            default: ;
        endcase

        // Flush overrides everything in the same cycle; a pop it kills
        // therefore never produces a writeback.
        if (flush_i) begin
            translation_req_o = 1'b0;
            st_valid_o        = 1'b0;
            pop               = 1'b0;
            pop_ex            = 1'b0;
        end

        count_d = count_q + CW'(push) - CW'(pop);
        if (flush_i) begin
            count_d = '0;
        end

        // Re-evaluating from count_d lets a hit chain straight into the next
        // entry without an IDLE bubble.
        if (pop || state_q == IDLE) begin
            state_d = (count_d != '0) ? XLATE : IDLE;
        end
        if (flush_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            paddr_q       <= '0;
            wb_valid_q    <= 1'b0;
            wb_ex_q       <= 1'b0;
            wb_trans_id_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            paddr_q    <= paddr_d;
            wb_valid_q <= pop;
            wb_ex_q    <= pop_ex;
            if (pop) begin
                wb_trans_id_q <= head.trans_id;
            end
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
                if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

    // Payload storage needs no reset: occupancy and pointers define validity.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{vaddr:    req_if.vaddr,
                                 data:     req_if.data,
                                 be:       req_if.be,
                                 size:     req_if.size,
                                 trans_id: req_if.trans_id};
        end
    end
endmodule

// File: tb/tb_store_unit_mq.sv
// Bench for store_unit_mq: directed stores, scoreboard queues filled at issue,
// monitor compares store-buffer and writeback traffic as it appears.
module tb_store_unit_mq;
    localparam logic [55:0] PX = 56'h80_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        translation_req_o;
    logic [38:0] vaddr_o;
    logic        dtlb_hit_i;
    logic [55:0] paddr_i;
    logic        ex_valid_i;
    logic        st_valid_o;
    logic        st_ready_i;
    logic [55:0] st_paddr_o;
    logic [63:0] st_data_o;
    logic [7:0]  st_be_o;
    logic [1:0]  st_size_o;
    logic        wb_valid_o;
    logic [2:0]  wb_trans_id_o;
    logic        wb_ex_o;
    logic [2:0]  count_o;
    logic        empty_o;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [55:0] paddr;
        logic [63:0] data;
        logic [7:0]  be;
        logic [1:0]  size;
    } st_exp_t;

    typedef struct packed {
        logic [2:0] id;
        logic       ex;
    } wb_exp_t;

    st_exp_t exp_st[$];
    wb_exp_t exp_wb[$];
    bit      hs_prev;

    always #5 clk = ~clk;

    store_unit_mq_if #(.XLEN(64), .VLEN(39), .TRANS_ID_BITS(3)) mq_if ();

    // MMU stub: physical address is the virtual address with the top bit set.
    assign paddr_i = {17'h0, vaddr_o} ^ PX;

    store_unit_mq #(
        .XLEN(64), .VLEN(39), .PLEN(56), .DEPTH(4), .TRANS_ID_BITS(3)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .flush_i           (flush_i),
        .req_if            (mq_if.slave),
        .translation_req_o (translation_req_o),
        .vaddr_o           (vaddr_o),
        .dtlb_hit_i        (dtlb_hit_i),
        .paddr_i           (paddr_i),
        .ex_valid_i        (ex_valid_i),
        .st_valid_o        (st_valid_o),
        .st_ready_i        (st_ready_i),
        .st_paddr_o        (st_paddr_o),
        .st_data_o         (st_data_o),
        .st_be_o           (st_be_o),
        .st_size_o         (st_size_o),
        .wb_valid_o        (wb_valid_o),
        .wb_trans_id_o     (wb_trans_id_o),
        .wb_ex_o           (wb_ex_o),
        .count_o           (count_o),
        .empty_o           (empty_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        st_exp_t es;
        wb_exp_t ew;
        if (hs_prev) chk("wb_after_st", {63'h0, wb_valid_o}, 64'h1);
        hs_prev = st_valid_o && st_ready_i;
        if (st_valid_o && st_ready_i) begin
            if (exp_st.size() == 0) flag("st_unexpected");
            else begin
                es = exp_st.pop_front();
                chk("st_paddr", {8'h0, st_paddr_o}, {8'h0, es.paddr});
                chk("st_data", st_data_o, es.data);
                chk("st_be", {56'h0, st_be_o}, {56'h0, es.be});
                chk("st_size", {62'h0, st_size_o}, {62'h0, es.size});
            end
        end
        if (wb_valid_o) begin
            if (exp_wb.size() == 0) flag("wb_unexpected");
            else begin
                ew = exp_wb.pop_front();
                chk("wb_id", {61'h0, wb_trans_id_o}, {61'h0, ew.id});
                chk("wb_ex", {63'h0, wb_ex_o}, {63'h0, ew.ex});
            end
        end
    end

    // kind: 0 = store reaches the buffer, 1 = translation exception, 2 = dropped
    task automatic push(input logic [38:0] va, input logic [63:0] d, input logic [7:0] be,
                        input logic [1:0] sz, input logic [2:0] id,
                        input logic [63:0] ed, input logic [7:0] ebe, input int kind);
        int n = 0;
        while (!mq_if.ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) flag("push_ready_timeout");
        mq_if.valid    = 1'b1;
        mq_if.vaddr    = va;
        mq_if.data     = d;
        mq_if.be       = be;
        mq_if.size     = sz;
        mq_if.trans_id = id;
        if (kind == 0) exp_st.push_back('{paddr: {17'h0, va} ^ PX, data: ed, be: ebe, size: sz});
        if (kind != 2) exp_wb.push_back('{id: id, ex: (kind == 1)});
        @(posedge clk); #1;
        mq_if.valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (!(exp_st.size() == 0 && exp_wb.size() == 0 && empty_o) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) flag("drain_timeout");
        @(posedge clk); #1;
    endtask

    initial begin
        rst_ni         = 1'b0;
        flush_i        = 1'b0;
        dtlb_hit_i     = 1'b1;
        ex_valid_i     = 1'b0;
        st_ready_i     = 1'b1;
        mq_if.valid    = 1'b0;
        mq_if.vaddr    = '0;
        mq_if.data     = '0;
        mq_if.be       = '0;
        mq_if.size     = '0;
        mq_if.trans_id = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {63'h0, mq_if.ready}, 64'h1);
        chk("rst_empty", {63'h0, empty_o}, 64'h1);
        chk("rst_count", {61'h0, count_o}, 64'h0);
        chk("rst_treq", {63'h0, translation_req_o}, 64'h0);
        chk("rst_st_valid", {63'h0, st_valid_o}, 64'h0);
        chk("rst_wb_valid", {63'h0, wb_valid_o}, 64'h0);
        chk("rst_wb_id", {61'h0, wb_trans_id_o}, 64'h0);
        chk("rst_wb_ex", {63'h0, wb_ex_o}, 64'h0);
        @(posedge clk); #1;
        rst_ni = 1'b1;

        // Byte-offset alignment: offset 3 and offset 5
        push(39'h1003, 64'hAB, 8'h01, 2'd0, 3'd2, 64'hAB00_0000, 8'h08, 0);
        drain();
        push(39'h2005, 64'h1234, 8'h03, 2'd1, 3'd3, 64'h0012_3400_0000_0000, 8'h60, 0);
        drain();

        // Fill to DEPTH with no translation, overflow attempt, then back-to-back hits
        dtlb_hit_i = 1'b0;
        for (int i = 0; i < 4; i++)
            push(39'(i * 256), 64'(i + 16), 8'hFF, 2'd3, 3'(i), 64'(i + 16), 8'hFF, 0);
        @(negedge clk);
        chk("full_ready", {63'h0, mq_if.ready}, 64'h0);
        chk("full_count", {61'h0, count_o}, 64'h4);
        chk("xlate_treq", {63'h0, translation_req_o}, 64'h1);
        chk("xlate_vaddr", {25'h0, vaddr_o}, 64'h0);
        @(posedge clk); #1;
        mq_if.valid    = 1'b1;
        mq_if.trans_id = 3'd7;
        @(posedge clk); #1;
        mq_if.valid = 1'b0;
        @(negedge clk);
        chk("overflow_count", {61'h0, count_o}, 64'h4);
        @(posedge clk); #1;
        dtlb_hit_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("b2b_st_valid", {63'h0, st_valid_o}, 64'h1);
        end
        @(negedge clk);
        chk("b2b_count_after", {61'h0, count_o}, 64'h0);
        chk("b2b_st_valid_after", {63'h0, st_valid_o}, 64'h0);
        @(posedge clk); #1;
        drain();

        // Store buffer stalls three cycles
        st_ready_i = 1'b0;
        push(39'h3000, 64'h55, 8'h01, 2'd0, 3'd4, 64'h55, 8'h01, 0);
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!st_valid_o && n < 20);
            if (!st_valid_o) flag("wait_buf_timeout");
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("wait_st_valid", {63'h0, st_valid_o}, 64'h1);
            chk("wait_paddr_stable", {8'h0, st_paddr_o}, {8'h0, {17'h0, 39'h3000} ^ PX});
            chk("wait_treq_low", {63'h0, translation_req_o}, 64'h0);
        end
        @(posedge clk); #1;
        st_ready_i = 1'b1;
        @(negedge clk);
        chk("wait_st_valid_4th", {63'h0, st_valid_o}, 64'h1);
        @(negedge clk);
        chk("wait_st_valid_drop", {63'h0, st_valid_o}, 64'h0);
        chk("wait_count", {61'h0, count_o}, 64'h0);
        @(posedge clk); #1;
        drain();

        // Translation exception
        ex_valid_i = 1'b1;
        push(39'h4000, 64'h77, 8'h01, 2'd0, 3'd5, 64'h0, 8'h0, 1);
        drain();
        ex_valid_i = 1'b0;

        // Flush with three queued, simultaneous push and hit
        dtlb_hit_i = 1'b0;
        for (int i = 1; i < 4; i++)
            push(39'h6000, 64'h0, 8'h01, 2'd0, 3'(i), 64'h0, 8'h0, 2);
        mq_if.valid    = 1'b1;
        mq_if.vaddr    = 39'h6000;
        mq_if.trans_id = 3'd6;
        dtlb_hit_i     = 1'b1;
        flush_i        = 1'b1;
        @(negedge clk);
        chk("flush_st_valid", {63'h0, st_valid_o}, 64'h0);
        chk("flush_treq", {63'h0, translation_req_o}, 64'h0);
        chk("flush_pre_count", {61'h0, count_o}, 64'h3);
        @(posedge clk); #1;
        mq_if.valid = 1'b0;
        flush_i     = 1'b0;
        dtlb_hit_i  = 1'b0;
        @(negedge clk);
        chk("flush_count", {61'h0, count_o}, 64'h0);
        chk("flush_empty", {63'h0, empty_o}, 64'h1);
        chk("flush_wb_valid", {63'h0, wb_valid_o}, 64'h0);
        chk("flush_idle_treq", {63'h0, translation_req_o}, 64'h0);
        @(negedge clk);
        chk("flush_idle_treq2", {63'h0, translation_req_o}, 64'h0);
        @(posedge clk); #1;
        dtlb_hit_i = 1'b1;

        // Pointer wrap: ten stores, ids 0..9 mod 8
        for (int i = 0; i < 10; i++)
            push(39'h5000 + 39'(i * 64), 64'(i + 256), 8'h01, 2'd0, 3'(i),
                 64'(i + 256), 8'h01, 0);
        drain();

        // Reset mid-operation drops pending entries silently
        dtlb_hit_i = 1'b0;
        push(39'h7000, 64'h1, 8'h01, 2'd0, 3'd1, 64'h0, 8'h0, 2);
        push(39'h7008, 64'h2, 8'h01, 2'd0, 3'd2, 64'h0, 8'h0, 2);
        rst_ni = 1'b0;
        @(negedge clk);
        chk("mid_rst_count", {61'h0, count_o}, 64'h0);
        chk("mid_rst_empty", {63'h0, empty_o}, 64'h1);
        chk("mid_rst_st_valid", {63'h0, st_valid_o}, 64'h0);
        @(posedge clk); #1;
        rst_ni     = 1'b1;
        dtlb_hit_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_wb_valid", {63'h0, wb_valid_o}, 64'h0);
        end

        chk("sb_st_left", 64'(exp_st.size()), 64'h0);
        chk("sb_wb_left", 64'(exp_wb.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/store_unit_mq.md
STORE_UNIT_MQ -- requirements
Module: store_unit_mq

Interface
REQ-001 SHALL have parameter XLEN, default 64, data width (32 or 64).
REQ-002 SHALL have parameter VLEN, default 39, virtual address width.
REQ-003 SHALL have parameter PLEN, default 56, physical address width.
REQ-004 SHALL have parameter DEPTH, default 4, pending-translation queue entries (power of 2, 1..8).
REQ-005 SHALL have parameter TRANS_ID_BITS, default 3, transaction id width.
REQ-006 SHALL have port clk_i  in  1  clock; reset rst_ni, asynchronous, active-low; clock clk_i.
REQ-007 SHALL have port rst_ni  in  1  asynchronous active-low reset.
REQ-008 SHALL have port flush_i  in  1  discard all pending stores.
REQ-009 SHALL have ports valid_i in 1, ready_o out 1: store request handshake.
REQ-010 SHALL have ports vaddr_i in VLEN, data_i in XLEN, be_i in XLEN/8 (unshifted byte mask), size_i in 2, trans_id_i in TRANS_ID_BITS.
REQ-011 SHALL have ports translation_req_o out 1, vaddr_o out VLEN, dtlb_hit_i in 1, paddr_i in PLEN, ex_valid_i in 1: MMU interface.
REQ-012 SHALL have ports st_valid_o out 1, st_ready_i in 1, st_paddr_o out PLEN, st_data_o out XLEN, st_be_o out XLEN/8, st_size_o out 2: store-buffer interface.
REQ-013 SHALL have ports wb_valid_o out 1, wb_trans_id_o out TRANS_ID_BITS, wb_ex_o out 1: writeback.
REQ-014 SHALL have ports count_o out clog2(DEPTH)+1 (occupancy), empty_o out 1.

Function
REQ-015 Queue SHALL be FIFO of DEPTH entries {vaddr, data, be, size, trans_id}; circular read/write pointers wrap modulo DEPTH.
REQ-016 ready_o SHALL be (count < DEPTH); independent of same-cycle pop.
REQ-017 Push SHALL occur on valid_i & ready_o & !flush_i; simultaneous push and pop SHALL leave count unchanged.
REQ-018 FSM states IDLE, XLATE, WAIT_BUF; IDLE -> XLATE when queue non-empty next cycle.
REQ-019 In XLATE: translation_req_o=1, vaddr_o=head vaddr, held stable until head pops.
REQ-020 XLATE, dtlb_hit_i & ex_valid_i: pop head, st_valid_o=0, wb next cycle with wb_ex_o=1.
REQ-021 XLATE, dtlb_hit_i & !ex_valid_i & st_ready_i: st_valid_o=1 same cycle using paddr_i, pop head.
REQ-022 XLATE, dtlb_hit_i & !ex_valid_i & !st_ready_i: register paddr_i, go WAIT_BUF, translation_req_o deasserted from next cycle.
REQ-023 WAIT_BUF: st_valid_o=1 with registered paddr; on st_ready_i pop head; st_* SHALL stay stable while waiting.
REQ-024 After any pop: next state XLATE if entries remain (excluding popped), else IDLE; no bubble between back-to-back hits.
REQ-025 No dtlb_hit_i in XLATE: remain, no pop.
REQ-026 st_data_o SHALL be head data shifted left by 8*vaddr[log2(XLEN/8)-1:0] bits; st_be_o = be shifted by same byte offset, truncated to XLEN/8.
REQ-027 wb_valid_o SHALL pulse exactly one cycle after each pop; wb_trans_id_o = popped trans_id; wb_ex_o per REQ-020, else 0.
REQ-028 flush_i SHALL: empty queue, force IDLE next cycle, force st_valid_o=0 and translation_req_o=0 same cycle, suppress wb_valid_o for any pop in that cycle, block push.
REQ-029 empty_o = (count == 0); count_o registered occupancy.

Reset
REQ-030 On rst_ni low: queue empty, pointers 0, state IDLE, registered paddr 0.
REQ-031 During/after reset until first push: ready_o=1, empty_o=1, count_o=0, translation_req_o=0, st_valid_o=0, wb_valid_o=0, wb_trans_id_o=0, wb_ex_o=0.
REQ-032 Reset asserted mid-operation SHALL drop all pending entries with no wb_valid_o.

Verification
REQ-033 Push vaddr 0x1003, data 0xAB, be 0x01, id 2; hit, st_ready_i=1 -> same cycle st_be_o=0x08, st_data_o=0xAB000000; next cycle wb_valid_o=1, id 2.
REQ-034 Push DEPTH=4 stores, dtlb_hit_i=0 -> ready_o=0, count_o=4; 5th valid_i not accepted; then hits -> 4 pops on consecutive cycles, ids in order.
REQ-035 Hit with st_ready_i=0 for 3 cycles then 1 -> st_valid_o high 4 cycles, st_paddr_o constant, one pop, one wb.
REQ-036 Hit with ex_valid_i=1, id 5 -> no st_valid_o, next cycle wb_valid_o=1, wb_ex_o=1, id 5.
REQ-037 Queue count 3, flush_i asserted with simultaneous push and hit -> next cycle count_o=0, empty_o=1, no wb_valid_o, state IDLE.
REQ-038 Pointer wrap: 10 sequential single pushes/pops with DEPTH=4 -> ids emitted in order 0..9 mod 2^TRANS_ID_BITS.
